// File: rtl/hub75_pkg.sv
// Shared types and constants for the 64x64 1/32-scan HUB75 scan driver.
// Panel geometry, scan FSM states and connector bit positions.
package hub75_pkg;

  typedef enum logic [1:0] {
    ST_SHIFT,
    ST_HOLD,
    ST_BLANK,
    ST_LATCH
  } state_t;

  localparam int PANEL_W    = 64;
  localparam int SCAN_ROWS  = 32;
  localparam int FRAME_BITS = 13;

  localparam int LED_R0       = 0;
  localparam int LED_G0       = 1;
  localparam int LED_B0       = 2;
  localparam int LED_R1       = 3;
  localparam int LED_G1       = 4;
  localparam int LED_B1       = 5;
  localparam int LED_ADDR_LSB = 6;
  localparam int LED_SCLK     = 11;
  localparam int LED_LAT      = 12;
  localparam int LED_OE_N     = 13;

endpackage

// File: rtl/hub75_scan_driver.sv
// HUB75 scan engine: requests pixels from the painter, shifts both panel halves
// out column by column, then blanks, latches and advances the row address.
module hub75_scan_driver
  import hub75_pkg::*;
#(
  parameter int BLANK_CYCLES  = 2,
  parameter int DISPLAY_EXTRA = 0
) (
  input  logic                  clk,
  input  logic                  reset,
  output logic [5:0]            x,
  output logic [5:0]            y,
  output logic [FRAME_BITS-1:0] frame,
  input  logic [2:0]            rgb,
  output logic [15:0]           LED_PANEL
);

  state_t                state_reg, state_next;
  logic [1:0]            phase_reg, phase_next;
  logic [5:0]            col_reg, col_next;
  logic [4:0]            row_reg, row_next;
  logic [FRAME_BITS-1:0] frame_reg, frame_next;
  logic [15:0]           cnt_reg, cnt_next;
  logic [5:0]            x_reg, x_next;
  logic [5:0]            y_reg, y_next;
  logic [2:0]            top_reg, top_next;
  logic [5:0]            data_reg, data_next;
  logic [4:0]            addr_reg, addr_next;
  logic                  sclk_reg, sclk_next;
  logic                  lat_reg, lat_next;
  logic                  oe_n_reg, oe_n_next;
  logic                  lit_reg, lit_next;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg <= ST_SHIFT;
      phase_reg <= '0;
      col_reg   <= '0;
      row_reg   <= '0;
      frame_reg <= '0;
      cnt_reg   <= '0;
      x_reg     <= '0;
      y_reg     <= '0;
      top_reg   <= '0;
      data_reg  <= '0;
      addr_reg  <= '0;
      sclk_reg  <= 1'b0;
      lat_reg   <= 1'b0;
      oe_n_reg  <= 1'b1;
      lit_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      phase_reg <= phase_next;
      col_reg   <= col_next;
      row_reg   <= row_next;
      frame_reg <= frame_next;
      cnt_reg   <= cnt_next;
      x_reg     <= x_next;
      y_reg     <= y_next;
      top_reg   <= top_next;
      data_reg  <= data_next;
      addr_reg  <= addr_next;
      sclk_reg  <= sclk_next;
      lat_reg   <= lat_next;
      oe_n_reg  <= oe_n_next;
      lit_reg   <= lit_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    phase_next = phase_reg;
    col_next   = col_reg;
    row_next   = row_reg;
    frame_next = frame_reg;
    cnt_next   = cnt_reg;
    x_next     = x_reg;
    y_next     = y_reg;
    top_next   = top_reg;
    data_next  = data_reg;
    addr_next  = addr_reg;
    lit_next   = lit_reg;

    unique case (state_reg)
      ST_SHIFT: begin
        phase_next = phase_reg + 2'd1;
        unique case (phase_reg)
          2'd0: begin
            top_next = rgb;
            y_next   = {1'b1, row_reg};
          end
          2'd1: data_next = {rgb, top_reg};
          2'd2: begin
          end
          default: begin
            if (col_reg == 6'(PANEL_W - 1)) begin
              cnt_next = '0;
              if (DISPLAY_EXTRA > 0) begin
                state_next = ST_HOLD;
              end else begin
                state_next = ST_BLANK;
                addr_next  = row_reg;
              end
            end else begin
              col_next = col_reg + 6'd1;
              x_next   = col_reg + 6'd1;
              y_next   = {1'b0, row_reg};
            end
          end
        endcase
      end
      ST_HOLD: begin
        if (cnt_reg == 16'(DISPLAY_EXTRA - 1)) begin
          state_next = ST_BLANK;
          cnt_next   = '0;
          addr_next  = row_reg;
        end else begin
          cnt_next = cnt_reg + 16'd1;
        end
      end
      ST_BLANK: begin
        if (cnt_reg == 16'(BLANK_CYCLES - 1)) begin
          state_next = ST_LATCH;
        end else begin
          cnt_next = cnt_reg + 16'd1;
        end
      end
      default: begin
        // Latch ends the row: restart shifting on the next row, bump frame after the last one.
        state_next = ST_SHIFT;
        phase_next = '0;
        col_next   = '0;
        row_next   = row_reg + 5'd1;
        x_next     = '0;
        y_next     = {1'b0, row_reg + 5'd1};
        lit_next   = 1'b1;
        if (row_reg == 5'(SCAN_ROWS - 1)) begin
          frame_next = frame_reg + 1'b1;
        end
      end
    endcase

    sclk_next = (state_reg == ST_SHIFT) && (phase_reg == 2'd2);
    lat_next  = (state_next == ST_LATCH);
    oe_n_next = (state_next == ST_BLANK) || (state_next == ST_LATCH) || !lit_next;
  end

  always_comb begin
    LED_PANEL                         = '0;
    LED_PANEL[LED_R0]                 = data_reg[0];
    LED_PANEL[LED_G0]                 = data_reg[1];
    LED_PANEL[LED_B0]                 = data_reg[2];
    LED_PANEL[LED_R1]                 = data_reg[3];
    LED_PANEL[LED_G1]                 = data_reg[4];
    LED_PANEL[LED_B1]                 = data_reg[5];
    LED_PANEL[LED_ADDR_LSB +: 5]      = addr_reg;
    LED_PANEL[LED_SCLK]               = sclk_reg;
    LED_PANEL[LED_LAT]                = lat_reg;
    LED_PANEL[LED_OE_N]               = oe_n_reg;
  end

  assign x     = x_reg;
  assign y     = y_reg;
  assign frame = frame_reg;

endmodule

// File: tb/tb_hub75_scan_driver.sv
// Bench for hub75_scan_driver: two instances (default and stretched timing) checked
// every cycle against a row-period arithmetic model, plus a few literal pins.
module tb_hub75_scan_driver;

  localparam int PA = 259;   // 256 + 0 + 2 + 1
  localparam int PB = 265;   // 256 + 5 + 3 + 1
  localparam int DEA = 0;
  localparam int DEB = 5;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [5:0]  x_a, y_a, x_b, y_b;
  logic [12:0] frame_a, frame_b;
  logic [2:0]  rgb_a, rgb_b;
  logic [15:0] led_a, led_b;

  logic [2:0]  img [4096];
  int          t;
  int          checks = 0;
  int          errors = 0;
  int          base_a = 0;
  int          pass_no = 0;
  int          oe_cnt_b = 0;

  always #5 clk = ~clk;

  hub75_scan_driver dut_a (
    .clk(clk), .reset(reset), .x(x_a), .y(y_a), .frame(frame_a),
    .rgb(rgb_a), .LED_PANEL(led_a)
  );

  hub75_scan_driver #(.BLANK_CYCLES(3), .DISPLAY_EXTRA(5)) dut_b (
    .clk(clk), .reset(reset), .x(x_b), .y(y_b), .frame(frame_b),
    .rgb(rgb_b), .LED_PANEL(led_b)
  );

  // Painters: random image for A, the {x[0], y[5], 1} pattern for B.
  always_comb rgb_a = img[{y_a, x_a}];
  assign rgb_b = {x_b[0], y_b[5], 1'b1};

  always @(posedge clk or posedge reset) begin
    if (reset) t <= 0;
    else       t <= t + 1;
  end

  function automatic logic [2:0] paint(input bit sel, input int xx, input int yy);
    logic [5:0] xv, yv;
    xv = xx[5:0];
    yv = yy[5:0];
    if (sel) return {xv[0], yv[5], 1'b1};
    return img[{yv, xv}];
  endfunction

  function automatic logic [5:0] pix(input bit sel, input int c, input int r);
    return {paint(sel, c, r + 32), paint(sel, c, r)};
  endfunction

  function automatic logic [15:0] exp_led(input bit sel, input int tt, input int p, input int de);
    int o, r, col, ph;
    logic [5:0] d;
    logic [4:0] addr;
    logic sclk, lat, oe;
    o = tt % p; r = (tt / p) % 32; col = o / 4; ph = o % 4;
    if (o >= 256)        d = pix(sel, 63, r);
    else if (ph >= 2)    d = pix(sel, col, r);
    else if (col > 0)    d = pix(sel, col - 1, r);
    else if (tt >= p)    d = pix(sel, 63, (r + 31) % 32);
    else                 d = 6'd0;
    sclk = (o < 256) && (ph == 3);
    lat  = (o == p - 1);
    oe   = (o >= 256 + de) || (tt < p);
    if (o >= 256 + de)   addr = 5'(r);
    else if (tt >= p)    addr = 5'((r + 31) % 32);
    else                 addr = 5'd0;
    return {2'b00, oe, lat, sclk, addr, d};
  endfunction

  function automatic int exp_x(input int tt, input int p);
    int o;
    o = tt % p;
    return (o < 256) ? o / 4 : 63;
  endfunction

  function automatic int exp_y(input int tt, input int p);
    int o, r;
    o = tt % p; r = (tt / p) % 32;
    return (o < 256 && o % 4 == 0) ? r : r + 32;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s t=%0d actual=%0h required=%0h", name, t, act, expv);
    end
  endtask

  // Per-cycle compare against the model, sampled on the falling edge.
  initial begin
    forever begin
      @(negedge clk);
      if (reset) begin
        chk("rst_led_a", 32'(led_a), 32'h2000);
        chk("rst_led_b", 32'(led_b), 32'h2000);
        chk("rst_xyf_a", {7'd0, x_a, y_a, frame_a}, 32'd0);
        chk("rst_xyf_b", {7'd0, x_b, y_b, frame_b}, 32'd0);
      end else begin
        chk("led_a", 32'(led_a), 32'(exp_led(1'b0, t, PA, DEA)));
        chk("led_b", 32'(led_b), 32'(exp_led(1'b1, t, PB, DEB)));
        chk("x_a", 32'(x_a), 32'(exp_x(t, PA)));
        chk("y_a", 32'(y_a), 32'(exp_y(t, PA)));
        chk("x_b", 32'(x_b), 32'(exp_x(t, PB)));
        chk("y_b", 32'(y_b), 32'(exp_y(t, PB)));
        chk("frame_a", 32'(frame_a), 32'((base_a + t / (32 * PA)) % 8192));
        chk("frame_b", 32'(frame_b), 32'((t / (32 * PB)) % 8192));
        // Literal pins on the model
        if (t == 257) chk("lit_nolat_a", 32'(led_a[12]), 32'd0);
        if (t == 258) chk("lit_lat_a", 32'(led_a[15:6]), 32'h0C0);
        if (t == 264) chk("lit_lat_b", 32'(led_b[12]), 32'd1);
        if (t == 19)  chk("lit_col4_b", 32'(led_b[11:0]), 32'h819);
        if (t == 23)  chk("lit_col5_b", 32'(led_b[11:0]), 32'h83D);
        if (t == PB) oe_cnt_b = int'(led_b[13]);
        else if (t > PB && t < 2 * PB) oe_cnt_b += int'(led_b[13]);
        else if (t == 2 * PB) chk("lit_oe_high_b", 32'(oe_cnt_b), 32'd4);
        if (pass_no == 0) begin
          if (t == 32 * PA - 1) chk("lit_frame0_a", 32'(frame_a), 32'd0);
          if (t == 32 * PA)     chk("lit_frame1_a", 32'(frame_a), 32'd1);
          if (t == 64 * PA - 1) chk("lit_frame8191_a", 32'(frame_a), 32'd8191);
          if (t == 64 * PA)     chk("lit_wrap_a", 32'(frame_a), 32'd0);
        end
      end
    end
  end

  initial begin
    for (int i = 0; i < 4096; i++) img[i] = 3'($urandom_range(0, 7));
    #1 reset = 1'b1;
    repeat (3) @(posedge clk);
    #2 reset = 1'b0;

    // Jump frame A to the last frame value part way into the second frame.
    while (t < 32 * PA + 100) begin
      @(posedge clk);
      #2;
    end
    force dut_a.frame_reg = 13'd8191;
    base_a = 8190;
    @(posedge clk);
    #2 release dut_a.frame_reg;

    // Reset mid-row: row 7, column 30 of A.
    while (!(t > 64 * PA && (t % PA) == 120 && ((t / PA) % 32) == 7)) begin
      @(posedge clk);
      #2;
    end
    reset = 1'b1;
    base_a = 0;
    pass_no = 1;
    #1;
    chk("async_rst_led_a", 32'(led_a), 32'h2000);
    chk("async_rst_led_b", 32'(led_b), 32'h2000);
    chk("async_rst_xyf_a", {7'd0, x_a, y_a, frame_a}, 32'd0);
    repeat (2) @(posedge clk);
    #2 reset = 1'b0;

    while (t < 3 * PB + 10) begin
      @(posedge clk);
      #2;
    end
    @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog t=%0d actual=timeout required=finish", t);
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/hub75_scan_driver.md
# hub75_scan_driver

Scan engine for the 64×64 1/32-scan HUB75 panel; sits directly upstream of the pixel painter and directly drives the 16-bit panel connector. Generates the pixel coordinates and frame counter the painter consumes, samples the painter's 3-bit colour back, and assembles the upper-half and lower-half pixels into shift data. It then sequences the shift clock, latch, output enable and row address.

## Interface
- `BLANK_CYCLES`, 2: OE_N-high cycles before each latch (≥1)
- `DISPLAY_EXTRA`, 0: extra lit cycles per row after shifting completes (≥0)
- `clk` in 1: system clock
- `reset` in 1: asynchronous, active-high reset
- `x` out 6: column being requested from painter
- `y` out 6: row being requested from painter
- `frame` out 13: frame counter to painter
- `rgb` in 3: painter colour {B,G,R} for current `x`,`y`; combinational, sampled the same cycle
- `LED_PANEL` out 16: [0]R0 [1]G0 [2]B0 [3]R1 [4]G1 [5]B1 [10:6]A–E row address [11]SCLK [12]LAT [13]OE_N [15:14] constant 0

## Operation
- States: SHIFT, HOLD, BLANK, LATCH.
- SHIFT: 64 columns × 4 phases = 256 cycles; column counter `col` 0→63.
  - P0: x=col, y=row; capture rgb as top; SCLK=0.
  - P1: x=col, y=row+32; capture rgb as bottom.
  - P2: R0..B1 ← {bottom, top}; SCLK=0.
  - P3: SCLK=1; data unchanged.
  - After P3 of col 63: HOLD if DISPLAY_EXTRA>0, else BLANK.
- HOLD: DISPLAY_EXTRA cycles, OE_N=0, SCLK=0, then BLANK.
- BLANK: OE_N=1; on entry, A–E ← row just shifted; lasts BLANK_CYCLES cycles.
- LATCH: 1 cycle, LAT=1, OE_N=1. Row counter advances (31→0). On 31→0, frame increments (8191→0 wrap). Next state is SHIFT with OE_N=0.
- OE_N=0 throughout SHIFT/HOLD, except after reset until the first LATCH completes.
- Row 0 top pixel uses y=0, bottom y=32; row 31 uses y=31/y=63.
- `x`,`y` registered; change only at phase boundaries. Outside SHIFT they hold their last value.
- `frame` constant across all 32 rows of a frame.

## Timing
- Reset (async assert, sync release): state=SHIFT P0, col=0, row=0, frame=0, x=0, y=0, LED_PANEL=16'h2000 (OE_N=1, all else 0).
- First SHIFT cycle is the first clock edge after reset deasserts.
- Row period = 256 + DISPLAY_EXTRA + BLANK_CYCLES + 1 cycles; defaults give 259 cycles/row and 8288 cycles/frame.
- Data set-up to SCLK rise: 1 cycle (P2→P3). Hold after fall: data stays stable until the next P2.
- SCLK: exactly 64 rising edges per row; none outside SHIFT.
- LAT high only in LATCH, with SCLK=0 and OE_N=1.
- A–E never change while OE_N=0.
- Reset mid-row: immediate return to reset values; the partial row is discarded, and no LAT or SCLK glitch occurs after assertion.

## Structure
- Package `hub75_pkg`:
  - State enum.
  - LED_PANEL bit-index constants (R0…OE_N).
  - PANEL_W=64, SCAN_ROWS=32, FRAME_BITS=13.
- Single module; no sub-module. The phase/column/row counters and the FSM are small enough to live together.

## Test plan
- Reset, release → LED_PANEL=16'h2000 until the first LATCH, then OE_N=0. LAT first pulses at cycle 258 with defaults; LED_PANEL[10:6]=0 from the BLANK entry before it.
- Painter model rgb = {x[0], y[5], 1} → per row, 64 SCLK rises. Sampled at each rise: R0=R1=1, G0=0, G1=1, B0=B1=x[0] of that column.
- Run 32 rows → frame increments once, at the LATCH ending row 31. It is 0 for all earlier `x`/`y` requests and 1 for row 0 of the next frame.
- Force frame counter to 8191 and run → wraps to 0.
- DISPLAY_EXTRA=5, BLANK_CYCLES=3 → row period 265 cycles. OE_N high exactly 4 cycles per row; A–E change only in the first BLANK cycle.
- Assert reset at col 30 of row 7 → outputs return to reset values the same cycle. After release, the SHIFT sequence restarts at row 0 col 0, with no spurious LAT.
